// File: rtl/gpr_if.sv
// Register-file view shared between writeback (writer) and operand fetch (reader).
`default_nettype none

interface gpr_if;
   logic [31:0] gpr [32];

   modport reader (input gpr);
   modport writer (output gpr);
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// Dual-lane register-read stage: GPR read with writeback bypass, long-latency
// destination scoreboard, RAW/WAW stall and a registered operand bundle for exec.
`default_nettype none

module operand_fetch #(
   parameter int NWB = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              interlock,
   gpr_if.reader             gpr,
   input  logic              u_valid,
   input  logic [4:0]        u_ra,
   input  logic [4:0]        u_rb,
   input  logic [4:0]        u_rd,
   input  logic              u_rd_flag,
   input  logic              u_long,
   input  logic              l_valid,
   input  logic [4:0]        l_ra,
   input  logic [4:0]        l_rb,
   input  logic [4:0]        l_rd,
   input  logic              l_rd_flag,
   input  logic              l_long,
   input  logic [NWB-1:0]    wb_valid,
   input  logic [5*NWB-1:0]  wb_rd,
   input  logic [32*NWB-1:0] wb_data,
   output logic              stall,
   output logic [31:0]       u_opa,
   output logic [31:0]       u_opb,
   output logic [31:0]       l_opa,
   output logic [31:0]       l_opb,
   output logic              u_out_valid,
   output logic              l_out_valid,
   output logic [4:0]        u_out_rd,
   output logic              u_out_rd_flag,
   output logic [4:0]        l_out_rd,
   output logic              l_out_rd_flag,
   output logic [31:0]       busy
);

   logic [31:0] busy_q, busy_d;
   logic [31:0] rel;
   logic [31:0] rdy;
   logic        u_hz, l_hz, fire;
   logic [31:0] u_opa_d, u_opb_d, l_opa_d, l_opb_d;
   logic [31:0] u_opa_q, u_opb_q, l_opa_q, l_opb_q;
   logic        u_out_valid_q, l_out_valid_q;
   logic [4:0]  u_out_rd_q, l_out_rd_q;
   logic        u_out_rd_flag_q, l_out_rd_flag_q;

   always_comb begin
      rel = '0;
      for (int p = 0; p < NWB; p++) begin
         if (wb_valid[p]) rel[wb_rd[5*p +: 5]] = 1'b1;
      end
   end

   // A register being released this cycle is as good as not busy.
   assign rdy  = ~busy_q | rel;
   assign u_hz = u_valid & (~rdy[u_ra] | ~rdy[u_rb] | (u_rd_flag & u_long & ~rdy[u_rd]));
   assign l_hz = l_valid & (~rdy[l_ra] | ~rdy[l_rb] | (l_rd_flag & l_long & ~rdy[l_rd]));
   assign stall = u_hz | l_hz;
   assign fire  = ~stall & ~interlock;

   always_comb begin
      busy_d = busy_q & ~rel;
      if (fire && u_valid && u_rd_flag && u_long) busy_d[u_rd] = 1'b1;
      if (fire && l_valid && l_rd_flag && l_long) busy_d[l_rd] = 1'b1;
   end

   // Later ports override earlier ones, so the highest matching port wins.
   always_comb begin
      u_opa_d = gpr.gpr[u_ra];
      u_opb_d = gpr.gpr[u_rb];
      l_opa_d = gpr.gpr[l_ra];
      l_opb_d = gpr.gpr[l_rb];
      for (int p = 0; p < NWB; p++) begin
         if (wb_valid[p]) begin
            if (wb_rd[5*p +: 5] == u_ra) u_opa_d = wb_data[32*p +: 32];
            if (wb_rd[5*p +: 5] == u_rb) u_opb_d = wb_data[32*p +: 32];
            if (wb_rd[5*p +: 5] == l_ra) l_opa_d = wb_data[32*p +: 32];
            if (wb_rd[5*p +: 5] == l_rb) l_opb_d = wb_data[32*p +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q          <= '0;
         u_opa_q         <= '0;
         u_opb_q         <= '0;
         l_opa_q         <= '0;
         l_opb_q         <= '0;
         u_out_valid_q   <= 1'b0;
         l_out_valid_q   <= 1'b0;
         u_out_rd_q      <= '0;
         l_out_rd_q      <= '0;
         u_out_rd_flag_q <= 1'b0;
         l_out_rd_flag_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         if (fire) begin
            u_opa_q         <= u_opa_d;
            u_opb_q         <= u_opb_d;
            l_opa_q         <= l_opa_d;
            l_opb_q         <= l_opb_d;
            u_out_valid_q   <= u_valid;
            l_out_valid_q   <= l_valid;
            u_out_rd_q      <= u_rd;
            l_out_rd_q      <= l_rd;
            u_out_rd_flag_q <= u_rd_flag;
            l_out_rd_flag_q <= l_rd_flag;
         end else if (!interlock) begin
            u_out_valid_q <= 1'b0;
            l_out_valid_q <= 1'b0;
         end
      end
   end

   assign busy          = busy_q;
   assign u_opa         = u_opa_q;
   assign u_opb         = u_opb_q;
   assign l_opa         = l_opa_q;
   assign l_opb         = l_opb_q;
   assign u_out_valid   = u_out_valid_q;
   assign l_out_valid   = l_out_valid_q;
   assign u_out_rd      = u_out_rd_q;
   assign l_out_rd      = l_out_rd_q;
   assign u_out_rd_flag = u_out_rd_flag_q;
   assign l_out_rd_flag = l_out_rd_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, reads, bypass, RAW/WAW stall, interlock.
`default_nettype none

module tb_operand_fetch;
   localparam int NWB = 4;

   logic              clk;
   logic              rstn;
   logic              interlock;
   logic              u_valid, l_valid;
   logic [4:0]        u_ra, u_rb, u_rd, l_ra, l_rb, l_rd;
   logic              u_rd_flag, u_long, l_rd_flag, l_long;
   logic [NWB-1:0]    wb_valid;
   logic [5*NWB-1:0]  wb_rd;
   logic [32*NWB-1:0] wb_data;
   logic              stall;
   logic [31:0]       u_opa, u_opb, l_opa, l_opb;
   logic              u_out_valid, l_out_valid;
   logic [4:0]        u_out_rd, l_out_rd;
   logic              u_out_rd_flag, l_out_rd_flag;
   logic [31:0]       busy;

   int tests = 0;
   int fails = 0;

   gpr_if gpr_bus ();

   operand_fetch #(.NWB(NWB)) dut (
      .clk(clk), .rstn(rstn), .interlock(interlock), .gpr(gpr_bus),
      .u_valid(u_valid), .u_ra(u_ra), .u_rb(u_rb), .u_rd(u_rd),
      .u_rd_flag(u_rd_flag), .u_long(u_long),
      .l_valid(l_valid), .l_ra(l_ra), .l_rb(l_rb), .l_rd(l_rd),
      .l_rd_flag(l_rd_flag), .l_long(l_long),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall),
      .u_opa(u_opa), .u_opb(u_opb), .l_opa(l_opa), .l_opb(l_opb),
      .u_out_valid(u_out_valid), .l_out_valid(l_out_valid),
      .u_out_rd(u_out_rd), .u_out_rd_flag(u_out_rd_flag),
      .l_out_rd(l_out_rd), .l_out_rd_flag(l_out_rd_flag),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      interlock = 1'b0;
      u_valid = 1'b0; u_ra = '0; u_rb = '0; u_rd = '0; u_rd_flag = 1'b0; u_long = 1'b0;
      l_valid = 1'b0; l_ra = '0; l_rb = '0; l_rd = '0; l_rd_flag = 1'b0; l_long = 1'b0;
      wb_valid = '0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic test_reset();
      #1;
      tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy: got %h expected %h", busy, 32'h0); end
      tests++; if ({u_out_valid, l_out_valid, u_out_rd_flag, l_out_rd_flag} !== 4'b0) begin
         fails++; $display("FAIL reset_flags: got %b expected 0000", {u_out_valid, l_out_valid, u_out_rd_flag, l_out_rd_flag}); end
      tests++; if ({u_opa, u_opb, l_opa, l_opb, u_out_rd, l_out_rd} !== '0) begin
         fails++; $display("FAIL reset_data: got %h expected 0", {u_opa, u_opb, l_opa, l_opb, u_out_rd, l_out_rd}); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
   endtask

   task automatic test_plain_read();
      gpr_bus.gpr[3] = 32'h11; gpr_bus.gpr[4] = 32'h22;
      idle();
      u_valid = 1'b1; u_ra = 5'd3; u_rb = 5'd4; u_rd = 5'd10; u_rd_flag = 1'b1;
      l_valid = 1'b1; l_ra = 5'd4; l_rb = 5'd3;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL plain_stall: got %b expected 0", stall); end
      @(negedge clk);
      tests++; if (u_opa !== 32'h11 || u_opb !== 32'h22) begin
         fails++; $display("FAIL plain_u_ops: got %h/%h expected 11/22", u_opa, u_opb); end
      tests++; if (l_opa !== 32'h22 || l_opb !== 32'h11) begin
         fails++; $display("FAIL plain_l_ops: got %h/%h expected 22/11", l_opa, l_opb); end
      tests++; if ({u_out_valid, l_out_valid, u_out_rd, u_out_rd_flag} !== {1'b1, 1'b1, 5'd10, 1'b1}) begin
         fails++; $display("FAIL plain_ctrl: got %b%b %0d %b expected 11 10 1", u_out_valid, l_out_valid, u_out_rd, u_out_rd_flag); end
   endtask

   task automatic test_raw_long();
      idle();
      u_valid = 1'b1; u_ra = 5'd1; u_rb = 5'd2; u_rd = 5'd8; u_rd_flag = 1'b1; u_long = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 32'h0000_0100) begin fails++; $display("FAIL raw_set: got %h expected %h", busy, 32'h100); end
      for (int i = 0; i < 3; i++) begin
         idle();
         l_valid = 1'b1; l_ra = 5'd8; l_rb = 5'd3;
         #1;
         tests++; if (stall !== 1'b1) begin fails++; $display("FAIL raw_stall%0d: got %b expected 1", i, stall); end
         @(negedge clk);
         tests++; if (l_out_valid !== 1'b0 || u_out_rd !== 5'd8) begin
            fails++; $display("FAIL raw_bubble%0d: got valid %b rd %0d expected 0 8", i, l_out_valid, u_out_rd); end
      end
      idle();
      l_valid = 1'b1; l_ra = 5'd8; l_rb = 5'd3;
      wb_valid = 4'b0100; wb_rd[10 +: 5] = 5'd8; wb_data[64 +: 32] = 32'h3F80_0000;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL raw_release_stall: got %b expected 0", stall); end
      @(negedge clk);
      gpr_bus.gpr[8] = 32'h3F80_0000;
      tests++; if (l_opa !== 32'h3F80_0000 || l_opb !== 32'h11 || l_out_valid !== 1'b1) begin
         fails++; $display("FAIL raw_operand: got %h/%h v%b expected 3f800000/11 v1", l_opa, l_opb, l_out_valid); end
      tests++; if (busy !== 32'h0) begin fails++; $display("FAIL raw_clear: got %h expected 0", busy); end
   endtask

   task automatic test_bypass_priority();
      idle();
      u_valid = 1'b1; u_ra = 5'd5; u_rb = 5'd6; l_valid = 1'b1; l_ra = 5'd5; l_rb = 5'd5;
      wb_valid = 4'b1010;
      wb_rd = {5'd5, 5'd5, 5'd5, 5'd5};
      wb_data = {32'hB, 32'hD, 32'hA, 32'hC};
      @(negedge clk);
      gpr_bus.gpr[5] = 32'hB;
      tests++; if (u_opa !== 32'hB || l_opa !== 32'hB || l_opb !== 32'hB) begin
         fails++; $display("FAIL bypass_prio: got %h/%h/%h expected b", u_opa, l_opa, l_opb); end
      tests++; if (u_opb !== 32'h1000_0006) begin
         fails++; $display("FAIL bypass_nomatch: got %h expected 10000006", u_opb); end
   endtask

   task automatic test_waw();
      idle();
      u_valid = 1'b1; u_ra = 5'd1; u_rb = 5'd2; u_rd = 5'd7; u_rd_flag = 1'b1; u_long = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 32'h80) begin fails++; $display("FAIL waw_set: got %h expected 80", busy); end
      idle();
      l_valid = 1'b1; l_ra = 5'd1; l_rb = 5'd2; l_rd = 5'd7; l_rd_flag = 1'b1; l_long = 1'b1;
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL waw_stall: got %b expected 1", stall); end
      @(negedge clk);
      tests++; if (l_out_valid !== 1'b0 || u_out_valid !== 1'b0) begin
         fails++; $display("FAIL waw_bubble: got %b%b expected 00", u_out_valid, l_out_valid); end
      wb_valid = 4'b0001; wb_rd[0 +: 5] = 5'd7; wb_data[0 +: 32] = 32'h77;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL waw_release_stall: got %b expected 0", stall); end
      @(negedge clk);
      gpr_bus.gpr[7] = 32'h77;
      tests++; if (busy !== 32'h80 || l_out_valid !== 1'b1) begin
         fails++; $display("FAIL waw_set_wins: got busy %h valid %b expected 80 1", busy, l_out_valid); end
      idle();
      u_rd = 5'd12; u_rd_flag = 1'b1; u_long = 1'b1;
      wb_valid = 4'b0001; wb_rd[0 +: 5] = 5'd7; wb_data[0 +: 32] = 32'h78;
      @(negedge clk);
      gpr_bus.gpr[7] = 32'h78;
      tests++; if (busy !== 32'h0) begin fails++; $display("FAIL waw_clear_invalid: got %h expected 0", busy); end
   endtask

   task automatic test_interlock();
      idle();
      u_valid = 1'b1; u_ra = 5'd1; u_rb = 5'd2; u_rd = 5'd9; u_rd_flag = 1'b1; u_long = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 32'h200 || u_out_rd !== 5'd9) begin
         fails++; $display("FAIL ilk_setup: got busy %h rd %0d expected 200 9", busy, u_out_rd); end
      for (int i = 0; i < 3; i++) begin
         idle();
         interlock = 1'b1;
         u_valid = 1'b1; u_ra = 5'd3; u_rb = 5'd9; u_rd = 5'd11; u_rd_flag = 1'b1;
         if (i == 0) begin
            wb_valid = 4'b0001; wb_rd[0 +: 5] = 5'd9; wb_data[0 +: 32] = 32'h99;
         end
         @(negedge clk);
         if (i == 0) gpr_bus.gpr[9] = 32'h99;
         tests++; if (u_out_rd !== 5'd9 || u_opa !== 32'h1000_0001 || u_out_valid !== 1'b1) begin
            fails++; $display("FAIL ilk_frozen%0d: got rd %0d opa %h v%b expected 9 10000001 1", i, u_out_rd, u_opa, u_out_valid); end
         tests++; if (busy !== 32'h0) begin fails++; $display("FAIL ilk_release%0d: got %h expected 0", i, busy); end
      end
      idle();
      u_valid = 1'b1; u_ra = 5'd3; u_rb = 5'd9; u_rd = 5'd11; u_rd_flag = 1'b1;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ilk_drop_stall: got %b expected 0", stall); end
      @(negedge clk);
      tests++; if (u_out_rd !== 5'd11 || u_opa !== 32'h11 || u_opb !== 32'h99 || u_out_valid !== 1'b1) begin
         fails++; $display("FAIL ilk_accept: got rd %0d %h/%h v%b expected 11 11/99 1", u_out_rd, u_opa, u_opb, u_out_valid); end
   endtask

   task automatic test_reset_midrun();
      idle();
      u_valid = 1'b1; u_ra = 5'd3; u_rb = 5'd4; u_rd = 5'd8; u_rd_flag = 1'b1; u_long = 1'b1;
      l_valid = 1'b1; l_ra = 5'd4; l_rb = 5'd3; l_rd = 5'd9; l_rd_flag = 1'b1; l_long = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 32'h0000_0300) begin fails++; $display("FAIL rst_pre_busy: got %h expected 300", busy); end
      idle();
      #2 rstn = 1'b0;
      #1;
      tests++; if (busy !== 32'h0) begin fails++; $display("FAIL rst_async_busy: got %h expected 0", busy); end
      tests++; if ({u_out_valid, l_out_valid, u_out_rd_flag, l_out_rd_flag, u_out_rd, l_out_rd} !== '0) begin
         fails++; $display("FAIL rst_async_ctrl: got %b%b%b%b %0d %0d expected 0", u_out_valid, l_out_valid,
                           u_out_rd_flag, l_out_rd_flag, u_out_rd, l_out_rd); end
      tests++; if ({u_opa, u_opb, l_opa, l_opb} !== '0) begin
         fails++; $display("FAIL rst_async_ops: got %h expected 0", {u_opa, u_opb, l_opa, l_opb}); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;
      idle();
      for (int i = 0; i < 32; i++) gpr_bus.gpr[i] = 32'h1000_0000 + i;
      test_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      test_plain_read();
      test_raw_long();
      test_bypass_priority();
      test_waw();
      test_interlock();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
